// File: rtl/vga_fb_if.sv
// Framebuffer read bus between the VGA reader and the pixel BRAM.
interface vga_fb_if #(parameter int DW = 12);
  logic [18:0]   o_vga_addr;
  logic [DW-1:0] i_vga_data;

  modport master (output o_vga_addr, input  i_vga_data);
  modport slave  (input  o_vga_addr, output i_vga_data);
endinterface

// File: rtl/vga_fb_reader.sv
// VGA timing generator and framebuffer read side: one read address per active
// pixel, sync/DE delayed by the BRAM latency so colour and timing stay aligned.
module vga_fb_reader #(
  parameter int DW       = 12,
  parameter int RD_LAT   = 1,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic          i_clk,
  input  logic          i_rst,
  vga_fb_if.master      fb,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [DW-1:0] o_rgb,
  output logic          o_frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [18:0]   r_addr;

  logic w_h_end, w_v_end, w_active, w_last_px, w_hs, w_vs, w_fs;

  assign w_h_end   = (r_h == H_LAST);
  assign w_v_end   = (r_v == V_LAST);
  assign w_active  = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_last_px = (r_h == H_ACT_LAST) && (r_v == V_ACT_LAST);
  assign w_hs      = (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_vs      = (r_v >= VS_BEG) && (r_v < VS_END);
  assign w_fs      = (r_h == '0) && (r_v == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_end) begin
      r_h <= '0;
      r_v <= w_v_end ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  // Incremental raster address: avoids a y*640 multiplier, wraps on the last pixel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_addr <= '0;
    else if (w_active) r_addr <= w_last_px ? '0 : r_addr + 19'd1;
  end

  assign fb.o_vga_addr = r_addr;

  // Per stage: {frame_start, vsync_asserted, hsync_asserted, active}.
  logic [RD_LAT-1:0][3:0] r_dly;
  logic [3:0]             w_tap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dly <= '0;
    end else begin
      r_dly[0] <= {w_fs, w_vs, w_hs, w_active};
      for (int i = 1; i < RD_LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign w_tap = r_dly[RD_LAT-1];

  logic          r_de, r_hs_n, r_vs_n, r_fs;
  logic [DW-1:0] r_rgb;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_de   <= 1'b0;
      r_hs_n <= 1'b1;
      r_vs_n <= 1'b1;
      r_fs   <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_de   <= w_tap[0];
      r_hs_n <= ~w_tap[1];
      r_vs_n <= ~w_tap[2];
      r_fs   <= w_tap[3];
      r_rgb  <= w_tap[0] ? fb.i_vga_data : '0;
    end
  end

  assign o_de          = r_de;
  assign o_hsync       = r_hs_n;
  assign o_vsync       = r_vs_n;
  assign o_frame_start = r_fs;
  assign o_rgb         = r_rgb;
endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader on a reduced raster (25x11) with RD_LAT=1 and RD_LAT=3.
module tb_vga_fb_reader;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  vga_fb_if #(.DW(12)) fb1();
  vga_fb_if #(.DW(12)) fb3();

  // BRAM models: data = addr[11:0], returned RD_LAT cycles after the address
  logic [11:0] bram1;
  logic [2:0][11:0] bram3;
  always @(posedge clk) begin
    bram1 <= fb1.o_vga_addr[11:0];
    bram3 <= {bram3[1], bram3[0], fb3.o_vga_addr[11:0]};
  end
  assign fb1.i_vga_data = bram1;
  assign fb3.i_vga_data = bram3[2];

  logic hs1, vs1, de1, fs1, hs3, vs3, de3, fs3;
  logic [11:0] rgb1, rgb3;

  vga_fb_reader #(.DW(12), .RD_LAT(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u1 (
    .i_clk(clk), .i_rst(rst), .fb(fb1.master), .o_hsync(hs1), .o_vsync(vs1),
    .o_de(de1), .o_rgb(rgb1), .o_frame_start(fs1));

  vga_fb_reader #(.DW(12), .RD_LAT(3), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u3 (
    .i_clk(clk), .i_rst(rst), .fb(fb3.master), .o_hsync(hs3), .o_vsync(vs3),
    .o_de(de3), .o_rgb(rgb3), .o_frame_start(fs3));

  typedef struct packed {
    logic de, hs, vs, fs;
    logic [11:0] rgb;
    logic [18:0] addr;
  } exp_t;

  // Reference raster: position index k -> expected outputs and read address
  function automatic exp_t model(int k);
    exp_t e;
    int h, v, px;
    h = k % HT;
    v = (k / HT) % VT;
    px = v * HA + h;
    e.de  = (h < HA) && (v < VA);
    e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    e.fs  = (h == 0) && (v == 0);
    e.rgb = e.de ? 12'(px) : 12'd0;
    if (v >= VA || (v == VA - 1 && h >= HA)) e.addr = 19'd0;
    else if (h >= HA)                        e.addr = 19'((v + 1) * HA);
    else                                     e.addr = 19'(px);
    return e;
  endfunction

  localparam logic [15:0] RST_OUT = {1'b0, 1'b1, 1'b1, 1'b0, 12'h000};

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({de1, hs1, vs1, fs1, rgb1, fb1.o_vga_addr} !== {RST_OUT, 19'd0}) begin
      n_fail++;
      $display("FAIL reset_initial: got %h want %h", {de1, hs1, vs1, fs1, rgb1, fb1.o_vga_addr}, {RST_OUT, 19'd0});
    end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    n_tests++;
    if ({de1, hs1, vs1, fs1, rgb1, fb1.o_vga_addr} !== {RST_OUT, 19'd0}) begin
      n_fail++;
      $display("FAIL reset_async_lat1: got %h want %h", {de1, hs1, vs1, fs1, rgb1, fb1.o_vga_addr}, {RST_OUT, 19'd0});
    end
    n_tests++;
    if ({de3, hs3, vs3, fs3, rgb3, fb3.o_vga_addr} !== {RST_OUT, 19'd0}) begin
      n_fail++;
      $display("FAIL reset_async_lat3: got %h want %h", {de3, hs3, vs3, fs3, rgb3, fb3.o_vga_addr}, {RST_OUT, 19'd0});
    end
  endtask

  task automatic test_first_pixel();
    exp_t q[$];
    exp_t e;
    int de_cnt = 0;
    do_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      q.push_back(model(cyc));
      n_tests++;
      if (q.size() > 2) begin
        e = q.pop_front();
        if ({de1, hs1, vs1, fs1, rgb1} !== {e.de, e.hs, e.vs, e.fs, e.rgb}) begin
          n_fail++;
          $display("FAIL lat1_out cyc=%0d: got %h want %h", cyc, {de1, hs1, vs1, fs1, rgb1}, {e.de, e.hs, e.vs, e.fs, e.rgb});
        end
      end else if ({de1, hs1, vs1, fs1, rgb1} !== RST_OUT) begin
        n_fail++;
        $display("FAIL lat1_startup cyc=%0d: got %h want %h", cyc, {de1, hs1, vs1, fs1, rgb1}, RST_OUT);
      end
      if (cyc >= 2 && cyc <= 4) begin
        n_tests++;
        if ({fs1, de1, rgb1} !== {(cyc == 2), 1'b1, 12'(cyc - 2)}) begin
          n_fail++;
          $display("FAIL first_pixel cyc=%0d: got %h want %h", cyc, {fs1, de1, rgb1}, {(cyc == 2), 1'b1, 12'(cyc - 2)});
        end
      end
      de_cnt += int'(de1);
      @(negedge clk);
    end
    n_tests++;
    if (de_cnt != 3 * HA * VA) begin
      n_fail++;
      $display("FAIL de_count: got %0d want %0d", de_cnt, 3 * HA * VA);
    end
  endtask

  task automatic test_sync_geometry();
    logic phs = 1'b1, pvs = 1'b1;
    int hs_fall = -1, vs_fall = -1, n_vs_fall = 0, de_in_vs = 0;
    do_reset();
    for (int i = 0; i < 3 * FRAME + 10; i++) begin
      if (phs && !hs1) begin
        if (hs_fall >= 0) begin
          n_tests++;
          if (cyc - hs_fall != HT) begin
            n_fail++;
            $display("FAIL hsync_period: got %0d want %0d", cyc - hs_fall, HT);
          end
        end
        hs_fall = cyc;
      end
      if (!phs && hs1) begin
        n_tests++;
        if (cyc - hs_fall != HS) begin
          n_fail++;
          $display("FAIL hsync_width: got %0d want %0d", cyc - hs_fall, HS);
        end
      end
      if (pvs !== vs1) begin
        n_tests++;
        if ((cyc - 2) % HT != 0) begin
          n_fail++;
          $display("FAIL vsync_edge_align: got h=%0d want h=0", (cyc - 2) % HT);
        end
      end
      if (pvs && !vs1) begin
        if (vs_fall >= 0) begin
          n_tests++;
          if (cyc - vs_fall != FRAME) begin
            n_fail++;
            $display("FAIL vsync_period: got %0d want %0d", cyc - vs_fall, FRAME);
          end
        end
        vs_fall = cyc;
        n_vs_fall++;
      end
      if (!pvs && vs1) begin
        n_tests++;
        if (cyc - vs_fall != VS * HT) begin
          n_fail++;
          $display("FAIL vsync_width: got %0d want %0d", cyc - vs_fall, VS * HT);
        end
      end
      if (!vs1 && de1) de_in_vs++;
      phs = hs1;
      pvs = vs1;
      @(negedge clk);
    end
    n_tests++;
    if (n_vs_fall != 3 || de_in_vs != 0) begin
      n_fail++;
      $display("FAIL vsync_frames: got falls=%0d de_in_vs=%0d want falls=3 de_in_vs=0", n_vs_fall, de_in_vs);
    end
  endtask

  task automatic test_addr_wrap();
    exp_t e;
    int maxa = 0;
    do_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      e = model(cyc);
      n_tests++;
      if (fb1.o_vga_addr !== e.addr || fb3.o_vga_addr !== e.addr) begin
        n_fail++;
        $display("FAIL addr cyc=%0d: got %0d/%0d want %0d", cyc, fb1.o_vga_addr, fb3.o_vga_addr, e.addr);
      end
      if (cyc % FRAME == (VA - 1) * HT + HA - 1) begin
        n_tests++;
        if (fb1.o_vga_addr !== 19'(HA * VA - 1)) begin
          n_fail++;
          $display("FAIL addr_last_pixel: got %0d want %0d", fb1.o_vga_addr, HA * VA - 1);
        end
      end
      if (int'(fb1.o_vga_addr) > maxa) maxa = int'(fb1.o_vga_addr);
      @(negedge clk);
    end
    n_tests++;
    if (maxa != HA * VA - 1) begin
      n_fail++;
      $display("FAIL addr_max: got %0d want %0d", maxa, HA * VA - 1);
    end
  endtask

  task automatic test_rdlat3();
    exp_t q[$];
    exp_t e;
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      q.push_back(model(cyc));
      n_tests++;
      if (q.size() > 4) begin
        e = q.pop_front();
        if ({de3, hs3, vs3, fs3, rgb3} !== {e.de, e.hs, e.vs, e.fs, e.rgb}) begin
          n_fail++;
          $display("FAIL lat3_out cyc=%0d: got %h want %h", cyc, {de3, hs3, vs3, fs3, rgb3}, {e.de, e.hs, e.vs, e.fs, e.rgb});
        end
      end else if ({de3, hs3, vs3, fs3, rgb3} !== RST_OUT) begin
        n_fail++;
        $display("FAIL lat3_startup cyc=%0d: got %h want %h", cyc, {de3, hs3, vs3, fs3, rgb3}, RST_OUT);
      end
      if (cyc == 4) begin
        n_tests++;
        if ({de3, fs3, rgb3} !== {1'b1, 1'b1, 12'h000}) begin
          n_fail++;
          $display("FAIL lat3_first_pixel: got %h want %h", {de3, fs3, rgb3}, {1'b1, 1'b1, 12'h000});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_restart();
    int guard = 0;
    do_reset();
    while (cyc < 100 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (cyc != 100) begin
      n_fail++;
      $display("FAIL restart_wait: got cyc=%0d want 100", cyc);
    end
    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    n_tests++;
    if ({de1, hs1, vs1, fs1, rgb1, fb1.o_vga_addr} !== {RST_OUT, 19'd0}) begin
      n_fail++;
      $display("FAIL restart_async: got %h want %h", {de1, hs1, vs1, fs1, rgb1, fb1.o_vga_addr}, {RST_OUT, 19'd0});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (fs1 !== (cyc == 2)) begin
        n_fail++;
        $display("FAIL restart_fs cyc=%0d: got %b want %b", cyc, fs1, (cyc == 2));
      end
      n_tests++;
      if (fb1.o_vga_addr !== 19'(cyc)) begin
        n_fail++;
        $display("FAIL restart_addr cyc=%0d: got %0d want %0d", cyc, fb1.o_vga_addr, cyc);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_sync_geometry();
    test_addr_wrap();
    test_rdlat3();
    test_reset_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Read side of the pixel framebuffer. Generates 640x480@60 VGA timing from the 25 MHz pixel clock and issues one framebuffer read address per active pixel. Captures the returned BRAM data and drives registered sync, data-enable and 12-bit RGB to the display pins. Pipeline-compensates the BRAM read latency so that syncs, data-enable and colour stay aligned.

## Interface
- DW, 12, pixel width (4:4:4 RGB)
- RD_LAT, 1, framebuffer read latency in cycles, legal 1..4
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels (total 800)
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525)

- i_clk  in  1  25 MHz pixel clock; the block's only clock
- i_rst  in  1  asynchronous, active-high reset
- o_vga_addr  out  19  framebuffer read address, row-major, y*640+x
- i_vga_data  in  DW  framebuffer read data, valid RD_LAT cycles after address
- o_hsync  out  1  horizontal sync, active low
- o_vsync  out  1  vertical sync, active low
- o_de  out  1  active-video qualifier
- o_rgb  out  DW  pixel colour, forced 0 when o_de=0
- o_frame_start  out  1  one-cycle pulse coincident with output of pixel (0,0)

## Operation
- Stage 0: h counter 0..799 and v counter 0..524.
  - h wraps 799->0 and v increments on that wrap.
  - v wraps 524->0 when h=799.
- Active: h<640 and v<480.
- hsync asserted (low) for h in 656..751; vsync asserted (low) for v in 490..491.
- Address register, incremental (no multiplier):
  - Increments by 1 on every active cycle, except on pixel (639,479), where it loads 0.
  - Holds its value during blanking.
  - Result: during active pixel (h,v), o_vga_addr = v*640+h, and it never exceeds 307199.
- o_vga_addr is driven directly from the address register.
  - BRAM read enable is permanently asserted at the memory, so the address is meaningful every cycle.
- Delay lines of length RD_LAT carry active, hsync, vsync and frame-start (h=0,v=0) from stage 0.
- Output register, loaded every cycle:
  - o_de <= active delayed.
  - o_rgb <= active delayed ? i_vga_data : 0.
  - o_hsync/o_vsync <= delayed syncs.
  - o_frame_start <= delayed frame-start.
- No stalls, no backpressure; the block free-runs after reset.

## Timing
- Reset (async assert, synchronous release on i_clk):
  - h=v=0, address=0, all delay-line stages inactive.
  - Outputs: o_hsync=1, o_vsync=1, o_de=0, o_rgb=0, o_frame_start=0, o_vga_addr=0.
- First rising edge after reset release: counters at (0,0).
- End-to-end latency: outputs reflect the stage-0 position of RD_LAT+1 cycles earlier.
  - With RD_LAT=1, pixel (0,0) appears 2 cycles after stage 0 reaches (0,0).
- Line period 800 cycles; frame period 420000 cycles; active o_de run 640 cycles per line, 480 lines per frame.
- o_hsync low exactly 96 consecutive cycles per line.
- o_vsync low exactly 1600 consecutive cycles; its edges coincide with line-start positions (delayed h=0).
- o_rgb is never nonzero while o_de=0, including during the first RD_LAT+1 cycles after reset.
- Reset mid-frame:
  - Every output returns to its reset value immediately (asynchronously).
  - On release, timing restarts at (0,0) with address 0; no partial frame is resumed.

## Test plan
- Reset values: assert i_rst mid-line -> same cycle o_hsync=1, o_vsync=1, o_de=0, o_rgb=0, o_vga_addr=0, o_frame_start=0.
- First-pixel alignment, RD_LAT=1, BRAM model returning data=addr[11:0] -> o_frame_start and o_de rise 2 cycles after release; o_rgb=0x000, then 0x001, 0x002, …; 640 o_de cycles per line.
- Sync geometry -> o_hsync low 96 cycles with period 800; o_vsync low 1600 cycles with period 420000; o_de low throughout vsync lines.
- Address wrap -> o_vga_addr=307199 at stage (639,479); address holds 0 through vertical blanking; next frame's first active address is 0; o_vga_addr never exceeds 307199 over 3 frames.
- RD_LAT=3 with data=addr[11:0] -> o_de rises 4 cycles after (0,0); each o_rgb equals the low 12 bits of that pixel's address; hsync and de edges shift by the same 4 cycles.
- Reset released, re-asserted at cycle 1000, released again -> timing restarts; o_frame_start pulses exactly 2 cycles after second release (RD_LAT=1).
